// File: rtl/drfifo_sync.sv
// rtl/drfifo_sync.sv - clocked dual-rail four-phase FIFO bridge; DRFIFO_SYNC_EN adds two-flop input synchronizers
module drfifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_t,
  input  logic [WIDTH-1:0]           in_f,
  output logic                       in_ack,
  output logic [WIDTH-1:0]           out_t,
  output logic [WIDTH-1:0]           out_f,
  input  logic                       out_ack,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       err
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic {
    I_DATA,
    I_NULL
  } in_state_e;

  typedef enum logic [1:0] {
    O_IDLE,
    O_DATA,
    O_RTZ
  } out_state_e;

  // Rails and ack as seen by the FSMs (synchronized or direct)
  logic [WIDTH-1:0] in_t_s;
  logic [WIDTH-1:0] in_f_s;
  logic             out_ack_s;

`ifdef DRFIFO_SYNC_EN
  logic [WIDTH-1:0] in_t_m_q;
  logic [WIDTH-1:0] in_t_s_q;
  logic [WIDTH-1:0] in_f_m_q;
  logic [WIDTH-1:0] in_f_s_q;
  logic             out_ack_m_q;
  logic             out_ack_s_q;

  // Two-flop synchronizers per rail; monotonic rails make per-bit sync safe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_t_m_q    <= '0;
      in_t_s_q    <= '0;
      in_f_m_q    <= '0;
      in_f_s_q    <= '0;
      out_ack_m_q <= 1'b0;
      out_ack_s_q <= 1'b0;
    end else begin
      in_t_m_q    <= in_t;
      in_t_s_q    <= in_t_m_q;
      in_f_m_q    <= in_f;
      in_f_s_q    <= in_f_m_q;
      out_ack_m_q <= out_ack;
      out_ack_s_q <= out_ack_m_q;
    end
  end

  assign in_t_s    = in_t_s_q;
  assign in_f_s    = in_f_s_q;
  assign out_ack_s = out_ack_s_q;
`else
  assign in_t_s    = in_t;
  assign in_f_s    = in_f;
  assign out_ack_s = out_ack;
`endif

  // State and storage
  in_state_e        in_state_q;
  out_state_e       out_state_q;
  logic             in_ack_q;
  logic             err_q;
  logic [WIDTH-1:0] out_t_q;
  logic [WIDTH-1:0] out_f_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Completion detection on the incoming word
  logic word_complete;
  logic word_null;
  logic word_illegal;
  logic fifo_full;
  logic fifo_empty;
  logic [WIDTH-1:0] head;

  assign word_complete = &(in_t_s | in_f_s);
  assign word_null     = ~|(in_t_s | in_f_s);
  assign word_illegal  = |(in_t_s & in_f_s);
  assign fifo_full     = (level_q == LVL_FULL);
  assign fifo_empty    = (level_q == '0);
  assign head          = mem_q[rd_ptr_q];

  // Handshake decisions: write, discard of an illegal word, pop, output load
  logic wr_en;
  logic in_discard;
  logic pop_en;
  logic load_en;

  // An illegal word is acked and dropped even when full, so the producer never stalls on it
  always_comb begin
    wr_en      = 1'b0;
    in_discard = 1'b0;
    if (in_state_q == I_DATA) begin
      if (word_illegal) begin
        in_discard = 1'b1;
      end else if (word_complete && !fifo_full) begin
        wr_en = 1'b1;
      end
    end
  end

  assign pop_en  = (out_state_q == O_DATA) && out_ack_s;
  assign load_en = (out_state_q == O_IDLE) && !fifo_empty && !out_ack_s;

  // Next pointers and occupancy; simultaneous write and pop leave level unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_en, pop_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Word storage; the t rail carries the bit value, contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_t_s;
    end
  end

  // Producer-side four-phase controller with registered ack and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_q <= I_DATA;
      in_ack_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (in_state_q)
        I_DATA: begin
          if (wr_en || in_discard) begin
            in_ack_q   <= 1'b1;
            in_state_q <= I_NULL;
          end
          if (in_discard) begin
            err_q <= 1'b1;
          end
        end
        I_NULL: begin
          // Only a fully null word ends the phase; partial return-to-zero waits
          if (word_null) begin
            in_ack_q   <= 1'b0;
            in_state_q <= I_DATA;
          end
        end
        default: begin
          in_ack_q   <= 1'b0;
          in_state_q <= I_DATA;
        end
      endcase
    end
  end

  // Consumer-side four-phase controller; rails change only as whole registered words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state_q <= O_IDLE;
      out_t_q     <= '0;
      out_f_q     <= '0;
    end else begin
      case (out_state_q)
        O_IDLE: begin
          if (load_en) begin
            out_t_q     <= head;
            out_f_q     <= ~head;
            out_state_q <= O_DATA;
          end
        end
        O_DATA: begin
          if (out_ack_s) begin
            out_t_q     <= '0;
            out_f_q     <= '0;
            out_state_q <= O_RTZ;
          end
        end
        O_RTZ: begin
          if (!out_ack_s) begin
            out_state_q <= O_IDLE;
          end
        end
        default: begin
          out_t_q     <= '0;
          out_f_q     <= '0;
          out_state_q <= O_IDLE;
        end
      endcase
    end
  end

  assign in_ack = in_ack_q;
  assign out_t  = out_t_q;
  assign out_f  = out_f_q;
  assign level  = level_q;
  assign err    = err_q;

endmodule

// File: tb/tb_drfifo_sync.sv
// tb/tb_drfifo_sync.sv - self-checking bench for drfifo_sync against a queue model
`timescale 1ns/1ps
module tb_drfifo_sync;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef DRFIFO_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_t = '0;
  logic [7:0] in_f = '0;
  logic       in_ack;
  logic [7:0] out_t;
  logic [7:0] out_f;
  logic       out_ack = 1'b0;
  logic [2:0] level;
  logic       err;

  int checks = 0;
  int failures = 0;

  logic [7:0] model_q[$];
  logic       err_m = 1'b0;
  logic       prev_ack = 1'b0;
  logic       prev_valid = 1'b0;

  always #5 clk = ~clk;

  drfifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_t   (in_t),
    .in_f   (in_f),
    .in_ack (in_ack),
    .out_t  (out_t),
    .out_f  (out_f),
    .out_ack(out_ack),
    .level  (level),
    .err    (err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic out_valid();
    return (out_t | out_f) != 8'h00;
  endfunction

  // One clock; sample after the edge and compare against the queue model
  task automatic tick();
    logic v;
    @(posedge clk);
    #1;
    if (!rst_n) return;
    v = out_valid();
    if (in_ack && !prev_ack) begin
      if ((in_t & in_f) == 8'h00) model_q.push_back(in_t);
      else err_m = 1'b1;
    end
    if (v && !prev_valid) begin
      chk("out_head", {24'h0, out_t}, (model_q.size() != 0) ? {24'h0, model_q[0]} : 32'hDEADBEEF);
      chk("out_f_inv", {24'h0, out_f}, {24'h0, ~out_t});
    end
    if (!v && prev_valid && model_q.size() != 0) void'(model_q.pop_front());
    chk("level", {29'h0, level}, model_q.size());
    chk("err", {31'h0, err}, {31'h0, err_m});
    chk("rail_excl", {24'h0, out_t & out_f}, 32'h0);
    chk("rail_whole", {24'h0, v ? (out_t ^ out_f) : 8'hFF}, 32'hFF);
    prev_ack = in_ack;
    prev_valid = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_t = '0;
    in_f = '0;
    out_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_q.delete();
    err_m = 1'b0;
    prev_ack = 1'b0;
    prev_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input logic val, output int n);
    n = 0;
    while (in_ack !== val && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_valid(input logic val, output int n);
    n = 0;
    while (out_valid() !== val && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic send_word(input logic [7:0] t, input logic [7:0] f);
    int n;
    in_t = t;
    in_f = f;
    wait_ack(1'b1, n);
    chk("send_ack", {31'h0, in_ack}, 32'h1);
    in_t = '0;
    in_f = '0;
    wait_ack(1'b0, n);
    chk("send_release", {31'h0, in_ack}, 32'h0);
  endtask

  task automatic pop_one();
    int n;
    out_ack = 1'b1;
    wait_valid(1'b0, n);
    chk("pop_null", {31'h0, out_valid()}, 32'h0);
    out_ack = 1'b0;
  endtask

  task automatic drain();
    int n;
    int guard;
    guard = 0;
    while (model_q.size() != 0 && guard < 20) begin
      wait_valid(1'b1, n);
      chk("drain_valid", {31'h0, out_valid()}, 32'h1);
      pop_one();
      guard++;
    end
    chk("drain_level", {29'h0, level}, 32'h0);
  endtask

  initial begin
    int n;
    int p;
    int c;
    logic [7:0] rt;
    logic [7:0] rf;
    logic [7:0] b;

    // Reset state
    do_reset();
    chk("rst_in_ack", {31'h0, in_ack}, 32'h0);
    chk("rst_out_t", {24'h0, out_t}, 32'h0);
    chk("rst_out_f", {24'h0, out_f}, 32'h0);
    chk("rst_level", {29'h0, level}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);

    // Single word: ack latency, fall-through, pop latency
    in_t = 8'hA5;
    in_f = 8'h5A;
    wait_ack(1'b1, n);
    chk("in_ack_latency", n, 1 + S);
    chk("single_level", {29'h0, level}, 32'h1);
    tick();
    chk("fallthrough_t", {24'h0, out_t}, 32'hA5);
    chk("fallthrough_f", {24'h0, out_f}, 32'h5A);
    in_t = '0;
    in_f = '0;
    wait_ack(1'b0, n);
    chk("release_latency", n, 1 + S);
    out_ack = 1'b1;
    wait_valid(1'b0, n);
    chk("pop_latency", n, 1 + S);
    out_ack = 1'b0;
    chk("single_empty", {29'h0, level}, 32'h0);

    // Fill to full and backpressure
    for (int w = 1; w <= 4; w++) send_word(8'(w), ~8'(w));
    chk("full_level", {29'h0, level}, 32'h4);
    in_t = 8'h05;
    in_f = 8'hFA;
    repeat (10) tick();
    chk("full_backpressure", {31'h0, in_ack}, 32'h0);
    pop_one();
    wait_ack(1'b1, n);
    chk("fifth_acked", {31'h0, in_ack}, 32'h1);
    in_t = '0;
    in_f = '0;
    wait_ack(1'b0, n);
    drain();

    // Simultaneous write and pop at level 2
    send_word(8'h3C, 8'hC3);
    send_word(8'h96, 8'h69);
    wait_valid(1'b1, n);
    for (int it = 0; it < 16; it++) begin
      rt = 8'($urandom);
      in_t = rt;
      in_f = ~rt;
      out_ack = 1'b1;
      wait_ack(1'b1, n);
      chk("simul_level", {29'h0, level}, 32'h2);
      chk("simul_popped", {31'h0, out_valid()}, 32'h0);
      in_t = '0;
      in_f = '0;
      out_ack = 1'b0;
      n = 0;
      while ((in_ack !== 1'b0 || out_valid() !== 1'b1) && n < 40) begin
        tick();
        n++;
      end
      chk("simul_rearm", {30'h0, in_ack, out_valid()}, 32'h1);
    end
    drain();

    // Illegal code: err sticky, handshake still completes, nothing stored
    send_word(8'h81, 8'h7F);
    chk("illegal_err", {31'h0, err}, 32'h1);
    chk("illegal_level", {29'h0, level}, 32'h0);
    send_word(8'h42, 8'hBD);
    drain();
    chk("illegal_sticky", {31'h0, err}, 32'h1);

    // Reset while presenting a word with level 3
    for (int w = 0; w < 3; w++) send_word(8'h10 + 8'(w), ~(8'h10 + 8'(w)));
    wait_valid(1'b1, n);
    chk("pre_rst_level", {29'h0, level}, 32'h3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_t", {24'h0, out_t}, 32'h0);
    chk("mid_rst_out_f", {24'h0, out_f}, 32'h0);
    chk("mid_rst_in_ack", {31'h0, in_ack}, 32'h0);
    chk("mid_rst_level", {29'h0, level}, 32'h0);
    chk("mid_rst_err", {31'h0, err}, 32'h0);
    do_reset();
    send_word(8'hE7, 8'h18);
    send_word(8'h00, 8'hFF);
    drain();

    // Randomized producer/consumer traffic against the queue model
    p = 0;
    c = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      if (cyc >= 1200 && p == 0 && c == 0 && model_q.size() == 0) break;
      case (p)
        0: if (cyc < 1200 && $urandom_range(3) == 0) begin
          rt = 8'($urandom);
          rf = ~rt;
          if ($urandom_range(9) == 0) begin
            b = 8'h01 << $urandom_range(7);
            rt = rt | b;
            rf = rf | b;
          end
          in_t = rt;
          in_f = rf;
          p = 1;
        end
        1: if (in_ack && $urandom_range(1) == 0) begin
          in_t = '0;
          in_f = '0;
          p = 2;
        end
        default: if (!in_ack) p = 0;
      endcase
      case (c)
        0: if (out_valid() && $urandom_range(2) == 0) begin
          out_ack = 1'b1;
          c = 1;
        end
        default: if (!out_valid() && $urandom_range(1) == 0) begin
          out_ack = 1'b0;
          c = 0;
        end
      endcase
    end
    chk("random_quiesced", {29'h0, p == 0, c == 0, model_q.size() == 0}, 32'h7);
    chk("random_final_level", {29'h0, level}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/drfifo_sync.md
# drfifo_sync

Clocked dual-rail FIFO bridge for WIDTH-bit dual-rail channels using four-phase return-to-zero signalling. A synchronous buffer of DEPTH words is placed between a dual-rail producer and a dual-rail consumer. Each side runs its own completion-detecting handshake controller. It is the multi-bit, buffered, clock-domain-aware successor to the single-bit dual-rail buffer, and it sits where dual-rail gate networks meet clocked logic.

## Interface
Parameters:
- WIDTH, 8: data bits per word; each bit is one t/f rail pair.
- DEPTH, 4: FIFO capacity in words; must be a power of two, minimum 2.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_t  input  WIDTH  producer true rails.
- in_f  input  WIDTH  producer false rails.
- in_ack  output  1  acknowledge to producer.
- out_t  output  WIDTH  consumer true rails.
- out_f  output  WIDTH  consumer false rails.
- out_ack  input  1  acknowledge from consumer.
- level  output  $clog2(DEPTH+1)  current number of stored words.
- err  output  1  sticky flag for an illegal input code.

## Operation
- Word states, per bit i:
  - Complete: every bit has in_t[i] | in_f[i].
  - Null: all in_t and in_f are 0.
  - Illegal: some bit has in_t[i] & in_f[i].
- Input FSM, states I_DATA and I_NULL (reset: I_DATA):
  - I_DATA, word complete and legal, FIFO not full: write in_t to the tail (bit value = t rail), set in_ack=1, go to I_NULL.
  - I_DATA, word complete and FIFO full: hold. No write, in_ack stays 0. This is backpressure.
  - I_DATA, word illegal: set err=1, discard the word (no write), set in_ack=1, go to I_NULL. Acking the illegal word prevents a deadlock.
  - I_NULL, word null: set in_ack=0, go to I_DATA. A partial return-to-zero is ignored.
- Output FSM, states O_IDLE, O_DATA, O_RTZ (reset: O_IDLE):
  - O_IDLE, FIFO not empty and out_ack=0: drive out_t=head, out_f=~head, go to O_DATA.
  - O_DATA, out_ack=1: pop the head, drive out_t=out_f=0, go to O_RTZ.
  - O_RTZ, out_ack=0: go to O_IDLE.
- Rail safety: out_t and out_f are registered outputs. They never show a partial word, and never have t and f high together on the same bit.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- A write and a pop in the same cycle are both performed; level is unchanged.
- level = writes - pops, in the range 0..DEPTH.
- Full means level==DEPTH; empty means level==0.
- err is cleared only by reset.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - in_ack=0, out_t=0, out_f=0, level=0, err=0;
  - FSMs to I_DATA and O_IDLE; pointers to 0; FIFO contents discarded.
- Reset mid-handshake: a complete word still held by the producer after release is accepted as a new word.
- S = synchronizer depth (2 with DRFIFO_SYNC_EN, 0 without).
- Input latency: a word stable before edge k is reflected in in_ack at edge k+S. The write occurs on that same edge.
- Input release latency: a null word stable before edge k drops in_ack at edge k+S.
- Fall-through: a word written at edge n onto an empty FIFO, with the output FSM in O_IDLE and out_ack low, appears on out_t/out_f at edge n+1+S_ack.
  - S_ack is 2 with the macro defined, 0 without; it applies only when out_ack was recently toggled.
  - When out_ack is already stable low, fall-through is n+1.
- Pop latency: out_ack high before edge k makes the outputs null at edge k+S.
- Throughput: at most one word per four handshake phases per side. Each phase costs at least 1+S cycles.

## Configuration
- DRFIFO_SYNC_EN defined:
  - in_t, in_f and out_ack each pass through a two-flop synchronizer before the FSMs.
  - Producer and consumer may be fully asynchronous to clk.
  - Per-rail synchronization is safe because dual-rail transitions are monotonic within each phase: completion is only declared once every rail has arrived.
- DRFIFO_SYNC_EN undefined:
  - Inputs are sampled directly; S=0.
  - Producer and consumer must be synchronous to clk.

## Test plan
- Reset then single word: WIDTH=8, present t=8'hA5 / f=8'h5A.
  - in_ack rises after 1+S edges; level becomes 1.
  - out_t=8'hA5, out_f=8'h5A appear next.
  - out_ack pulse returns the outputs to null and level to 0.
- Fill to full: DEPTH=4, consumer out_ack held low, producer sends 0x01..0x05.
  - Four words are acked; level reaches 4.
  - The fifth word stays un-acked until one pop.
  - Output order is 0x01..0x05.
- Simultaneous write and pop: with level=2, time a producer write and a consumer pop on the same edge.
  - level stays 2; no word is lost or duplicated across 16 iterations.
- Illegal code: present t=8'h01, f=8'h01 (plus complete rails on the other bits).
  - err rises and stays 1; in_ack still handshakes; level is unchanged.
- Reset mid-operation: assert rst_n=0 while in O_DATA with level=3.
  - Outputs go null immediately; in_ack=0, level=0, err=0.
  - After release, the FIFO resumes with fresh words.
